// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipeline stage register.
//   - stage occupancy state encoding
//   - default bubble (NOP) payload
//   - stage bundle widths derived from the core width macros
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  localparam int XLEN        = `XLEN;
  localparam int PC_WIDTH    = `PC_WIDTH;
  localparam int INSTR_WIDTH = `INSTR_WIDTH;

  // Per-stage bundle widths: PC + nPC + instr (+ valE) plus a small
  // control/training field.
  localparam int CTRL_WIDTH  = 8;
  localparam int DE_BUNDLE_W = 2 * PC_WIDTH + INSTR_WIDTH + CTRL_WIDTH;
  localparam int EX_BUNDLE_W = 2 * PC_WIDTH + INSTR_WIDTH + XLEN + CTRL_WIDTH;

  localparam int DEF_WIDTH = 64;

  // Bubble payload: all-zero decodes as a NOP throughout the pipe.
  localparam logic [DEF_WIDTH-1:0] NOP_PAYLOAD = '0;

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
//
// Ports:
//   clk_i        rising-edge clock
//   rst          asynchronous active-high reset
//   flush_i      synchronous kill; empties the stage, wins over transfers
//   in_valid_i / in_ready_o / in_data_i     upstream handshake
//   out_valid_o / out_ready_i / out_data_o  downstream handshake
//   count_o      occupancy 0..2
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no payload held, out_data_o = NOP_VALUE
// ST_FULL  | main entry valid and presented
// ST_SKID  | main presented, skid holds next payload (SKID=1)
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_PAYLOAD),
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;

  // With the skid buffer, ready is a flop so out_ready_i never reaches
  // in_ready_o combinationally. Without it, ready passes through.
  assign in_ready_o = SKID ? in_ready_q : (!out_valid_q || out_ready_i);

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_q && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_data_i;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            // Only reachable with SKID=1; SKID=0 ready forbids it.
            state_d = ST_SKID;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    count_d     = {state_d == ST_SKID, state_d == ST_FULL};
    in_ready_d  = (state_d != ST_SKID);
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_i = ~clk_i;

  // SKID=1 instance
  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;
  // SKID=0 instance
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_count;

  pipe_skid_reg #(.WIDTH(8), .NOP_VALUE(8'h00), .SKID(1'b1)) dut_a (
    .clk_i(clk_i), .rst(rst), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .count_o(a_count));

  pipe_skid_reg #(.WIDTH(8), .NOP_VALUE(8'h00), .SKID(1'b0)) dut_b (
    .clk_i(clk_i), .rst(rst), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .count_o(b_count));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [7:0] d,
                       input logic [1:0] c, input logic r);
    check({tag, ".valid"}, a_out_valid, v);
    check({tag, ".data"},  a_out_data,  d);
    check({tag, ".count"}, a_count,     c);
    check({tag, ".ready"}, a_in_ready,  r);
  endtask

  task automatic a_drive(input logic v, input logic [7:0] d, input logic r, input logic f);
    a_in_valid = v; a_in_data = d; a_out_ready = r; a_flush = f;
  endtask

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  initial begin
    a_drive(0, 8'h00, 0, 0);
    b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    #12;
    chk_a("reset", 0, 8'h00, 2'd0, 1);
    check("reset_b.valid", b_out_valid, 0);
    rst = 1'b0;
    tick();

    // Back-to-back streaming, one-cycle latency, count stays 1
    a_drive(1, 8'h11, 1, 0); tick(); chk_a("stream1", 1, 8'h11, 2'd1, 1);
    a_drive(1, 8'h22, 1, 0); tick(); chk_a("stream2", 1, 8'h22, 2'd1, 1);
    a_drive(1, 8'h33, 1, 0); tick(); chk_a("stream3", 1, 8'h33, 2'd1, 1);
    a_drive(0, 8'h00, 1, 0); tick(); chk_a("drain",   0, 8'h00, 2'd0, 1);

    // Fill into skid, stall, then drain in order
    a_drive(1, 8'h11, 0, 0); tick(); chk_a("fill1",  1, 8'h11, 2'd1, 1);
    a_drive(1, 8'h22, 0, 0); tick(); chk_a("skid",   1, 8'h11, 2'd2, 0);
    a_drive(1, 8'h99, 0, 0); tick(); chk_a("stall",  1, 8'h11, 2'd2, 0);
    a_drive(0, 8'h00, 1, 0); tick(); chk_a("pop1",   1, 8'h22, 2'd1, 1);
    tick();                          chk_a("pop2",   0, 8'h00, 2'd0, 1);

    // Flush from skid with coincident in_valid: payload is dropped
    a_drive(1, 8'hAA, 0, 0); tick();
    a_drive(1, 8'hBB, 0, 0); tick(); chk_a("pre_flush", 1, 8'hAA, 2'd2, 0);
    a_drive(1, 8'hCC, 0, 1); tick(); chk_a("flush",     0, 8'h00, 2'd0, 1);
    a_drive(0, 8'h00, 1, 0); tick(); chk_a("post_flush", 0, 8'h00, 2'd0, 1);

    // Async reset mid-cycle while in skid state
    a_drive(1, 8'hAA, 0, 0); tick();
    a_drive(1, 8'hBB, 0, 0); tick();
    a_drive(0, 8'h00, 0, 0);
    check("pre_rst.count", a_count, 2'd2);
    #2 rst = 1'b1;
    #1 chk_a("async_rst", 0, 8'h00, 2'd0, 1);
    #1 rst = 1'b0;
    a_drive(1, 8'h77, 1, 0); tick(); chk_a("after_rst", 1, 8'h77, 2'd1, 1);
    a_drive(0, 8'h00, 1, 0); tick();

    // SKID=0: combinational ready follows out_ready_i
    b_in_valid = 1; b_in_data = 8'h55; b_out_ready = 1; tick();
    check("b_full.data", b_out_data, 8'h55);
    check("b_full.count", b_count, 2'd1);
    b_in_data = 8'h66; b_out_ready = 0; #1;
    check("b_stall.ready", b_in_ready, 0);
    tick();
    check("b_stall.data", b_out_data, 8'h55);
    b_out_ready = 1; #1;
    check("b_go.ready", b_in_ready, 1);
    tick();
    check("b_next.data", b_out_data, 8'h66);
    check("b_next.count", b_count, 2'd1);
    b_in_valid = 0; tick();
    check("b_drain.valid", b_out_valid, 0);

    // Random traffic against a queue model on both instances
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic a_rdy_exp, b_rdy_exp, a_of, b_of, a_if, b_if;
      check("rnd_a.valid", a_out_valid, qa.size() != 0);
      check("rnd_a.data",  a_out_data,  qa.size() != 0 ? qa[0] : 8'h00);
      check("rnd_a.count", a_count,     qa.size());
      check("rnd_b.valid", b_out_valid, qb.size() != 0);
      check("rnd_b.data",  b_out_data,  qb.size() != 0 ? qb[0] : 8'h00);
      check("rnd_b.count", b_count,     qb.size());
      a_in_valid  = $urandom_range(0, 3) != 0;
      a_in_data   = 8'($urandom);
      a_out_ready = $urandom_range(0, 2) != 0;
      a_flush     = $urandom_range(0, 31) == 0;
      b_in_valid  = $urandom_range(0, 3) != 0;
      b_in_data   = 8'($urandom);
      b_out_ready = $urandom_range(0, 2) != 0;
      b_flush     = $urandom_range(0, 31) == 0;
      #1;
      a_rdy_exp = qa.size() < 2;
      b_rdy_exp = (qb.size() == 0) || b_out_ready;
      check("rnd_a.ready", a_in_ready, a_rdy_exp);
      check("rnd_b.ready", b_in_ready, b_rdy_exp);
      a_of = (qa.size() != 0) && a_out_ready;
      b_of = (qb.size() != 0) && b_out_ready;
      a_if = a_in_valid && a_rdy_exp;
      b_if = b_in_valid && b_rdy_exp;
      if (a_flush) qa.delete();
      else begin
        if (a_of) void'(qa.pop_front());
        if (a_if) qa.push_back(a_in_data);
      end
      if (b_flush) qb.delete();
      else begin
        if (b_of) void'(qb.pop_front());
        if (b_if) qb.push_back(b_in_data);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
